// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and defaults for the IF/MEM memory-port arbiter.
//   - arbState_t : arbiter FSM states
//   - DEF_*      : default address/data widths and BUSY abort limit
//   - isBusy()   : true while a port transaction is outstanding
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } arbState_t;

    function automatic logic isBusy(input arbState_t s);
        return (s == BUSY_IF) || (s == BUSY_DM);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// arb_timeout_counter
//   Counts BUSY cycles of the arbiter and flags the cycle in which the
//   TIMEOUT-th consecutive BUSY cycle is reached. Only instantiated when
//   ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, resetN : clock, async active-low reset
//   clr         : hold the count at zero (arbiter not busy)
//   en          : count this cycle (arbiter busy)
//   tc          : terminal count, high during the TIMEOUT-th enabled cycle
module arb_timeout_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic resetN,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    // cnt holds the number of BUSY cycles already completed, so the
    // TIMEOUT-th one is the cycle where cnt == TIMEOUT-1.
    assign tc = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the IF stage (fetch) and the
//   MEM stage (lw/sw). Data accesses win over fetches. Drives the memory
//   port handshake, returns read data to the winner and produces the
//   pipeline stall controls.
//   Optional feature: define ARB_TIMEOUT_EN to abort a BUSY transaction
//   after TIMEOUT cycles without portAck (valid pulses with data 0 and
//   errTimeout pulses). Without it BUSY waits forever, errTimeout stays 0.
// Ports:
//   clk, resetN                     : clock, async active-low reset
//   ifReq/ifAddr/ifFlush            : fetch request, PC, branch-taken flush
//   ifValid/ifData                  : fetch completion pulse and instruction
//   memReq/memWe/memAddr/memWData   : data access request
//   memValid/memRData               : data access completion pulse, load data
//   portReq/portWe/portAddr/portWData : memory port request (held to ack)
//   portAck/portRData               : memory port completion and read data
//   PCWrite/IF_ID_Write/pipeHold    : stall controls
//   errTimeout                      : pulse on an aborted transaction
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    input  logic              ifFlush,
    output logic              ifValid,
    output logic [DATA_W-1:0] ifData,
    input  logic              memReq,
    input  logic              memWe,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memWData,
    output logic              memValid,
    output logic [DATA_W-1:0] memRData,
    output logic              portReq,
    output logic              portWe,
    output logic [ADDR_W-1:0] portAddr,
    output logic [DATA_W-1:0] portWData,
    input  logic              portAck,
    input  logic [DATA_W-1:0] portRData,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              pipeHold,
    output logic              errTimeout
);

    arbState_t state, stateNext;
    logic      busy;
    logic      timedOut;
    logic      flushed;   // fetch in flight was squashed by a taken branch

    assign busy = isBusy(state);

`ifdef ARB_TIMEOUT_EN
    arb_timeout_counter #(.TIMEOUT(TIMEOUT)) uTimeout (
        .clk    (clk),
        .resetN (resetN),
        .clr    (~busy),
        .en     (busy),
        .tc     (timedOut)
    );
`else
    // No abort path: TIMEOUT has no effect in this build.
    localparam bit TimeoutCfgValid = (TIMEOUT > 0);
    assign timedOut = 1'b0 & TimeoutCfgValid;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (memReq)                 stateNext = BUSY_DM;
                else if (ifReq && !ifFlush) stateNext = BUSY_IF;
            end
            BUSY_IF, BUSY_DM: begin
                if (portAck || timedOut)    stateNext = RESP;
            end
            RESP:                           stateNext = IDLE;
            default:                        stateNext = IDLE;
        endcase
    end

    // ---------------- port registers and responses ----------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            portReq    <= 1'b0;
            portWe     <= 1'b0;
            portAddr   <= '0;
            portWData  <= '0;
            ifValid    <= 1'b0;
            memValid   <= 1'b0;
            ifData     <= '0;
            memRData   <= '0;
            errTimeout <= 1'b0;
            flushed    <= 1'b0;
        end else begin
            ifValid    <= 1'b0;
            memValid   <= 1'b0;
            errTimeout <= 1'b0;
            case (state)
                IDLE: begin
                    flushed <= 1'b0;
                    if (memReq) begin
                        portReq   <= 1'b1;
                        portWe    <= memWe;
                        portAddr  <= memAddr;
                        portWData <= memWData;
                    end else if (ifReq && !ifFlush) begin
                        portReq   <= 1'b1;
                        portWe    <= 1'b0;
                        portAddr  <= ifAddr;
                        portWData <= '0;
                    end
                end
                BUSY_IF: begin
                    if (ifFlush) flushed <= 1'b1;
                    if (portAck || timedOut) begin
                        portReq    <= 1'b0;
                        ifData     <= portAck ? portRData : '0;
                        // a flush arriving on the completing edge also squashes
                        ifValid    <= ~(flushed | ifFlush);
                        errTimeout <= ~portAck;
                    end
                end
                BUSY_DM: begin
                    if (portAck) begin
                        portReq  <= 1'b0;
                        memValid <= 1'b1;
                        if (!portWe) memRData <= portRData;
                    end else if (timedOut) begin
                        portReq    <= 1'b0;
                        memValid   <= 1'b1;
                        memRData   <= '0;
                        errTimeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- stall controls ----------------
    logic stallAny;
    assign stallAny    = (ifReq & ~ifValid & ~ifFlush) | (memReq & ~memValid);
    assign PCWrite     = resetN & ~stallAny;
    assign IF_ID_Write = resetN & ~stallAny;
    assign pipeHold    = ~resetN | (memReq & ~memValid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Table-driven directed vectors, hand-written multi-cycle sequences and
//   randomized accesses for mem_port_arbiter. Expected values come from a
//   transaction-level model: latency from the request cycle, data from a
//   fixed memory content function, and the stall equations.
module tb_mem_port_arbiter;

    localparam int TOUT = 15;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        ifReq = 1'b0, ifFlush = 1'b0, memReq = 1'b0, memWe = 1'b0;
    logic [31:0] ifAddr = '0, memAddr = '0, memWData = '0;
    logic        ifValid, memValid, portReq, portWe;
    logic [31:0] ifData, memRData, portAddr, portWData;
    logic        portAck = 1'b0;
    logic [31:0] portRData = '0;
    logic        PCWrite, IF_ID_Write, pipeHold, errTimeout;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TOUT)) dut (
        .clk(clk), .resetN(resetN),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifFlush(ifFlush),
        .ifValid(ifValid), .ifData(ifData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memValid(memValid), .memRData(memRData),
        .portReq(portReq), .portWe(portWe), .portAddr(portAddr), .portWData(portWData),
        .portAck(portAck), .portRData(portRData),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .pipeHold(pipeHold),
        .errTimeout(errTimeout)
    );

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memF(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    // ---------------- memory model ----------------
    bit          ackEnable = 1'b1;
    bit          forceAck  = 1'b0;
    int          ackDelay  = 0;
    int          waitCnt   = 0;
    logic [31:0] lastWAddr = '0, lastWData = '0;

    always begin
        @(negedge clk);
        #1;
        portAck = 1'b0;
        if (forceAck) begin
            portAck   = 1'b1;
            portRData = 32'hBAD0BAD0;
        end else if (portReq && ackEnable) begin
            if (waitCnt >= ackDelay) begin
                portAck   = 1'b1;
                portRData = memF(portAddr);
                waitCnt   = 0;
                if (portWe) begin
                    lastWAddr = portAddr;
                    lastWData = portWData;
                end
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    end

    // ---------------- transaction runner ----------------
    typedef struct {
        bit          doIf;
        bit          doMem;
        bit          we;
        int          flushAt;   // sample index at which to flush, -1 = none
        logic [31:0] ia;
        logic [31:0] ma;
        logic [31:0] wd;
        int          d;         // port ack delay after portReq rises
    } vec_t;

    logic [31:0] lastRData = '0;  // model of memRData

    task automatic stallCheck();
        bit stall;
        stall = (ifReq && !ifValid && !ifFlush) || (memReq && !memValid);
        check("PCWrite", PCWrite, !stall);
        check("IF_ID_Write", IF_ID_Write, !stall);
        check("pipeHold", pipeHold, memReq && !memValid);
    endtask

    task automatic runVec(input vec_t v);
        int expIfAt, expMemAt, win, ifCnt, memCnt;
        bit memDone, portBad;
        logic [31:0] eAddr;
        logic        eWe;
        ackDelay = v.d;
        @(negedge clk);
        ifReq = v.doIf; ifAddr = v.ia; ifFlush = 1'b0;
        memReq = v.doMem; memWe = v.we; memAddr = v.ma; memWData = v.wd;
        // request seen at cycle 0: portReq at 1, ack at 1+d, valid at 2+d,
        // IDLE again at 3+d where a held fetch is granted.
        expMemAt = v.doMem ? 2 + v.d : -1;
        expIfAt  = (!v.doIf || v.flushAt >= 0) ? -1 : (v.doMem ? 5 + 2 * v.d : 2 + v.d);
        win = 8 + 2 * v.d;
        memDone = 0; portBad = 0; ifCnt = 0; memCnt = 0;
        for (int i = 1; i <= win; i++) begin
            @(negedge clk);
            stallCheck();
            check("errTimeout idle", errTimeout, 1'b0);
            if (portReq) begin
                eAddr = (v.doMem && !memDone) ? v.ma : v.ia;
                eWe   = (v.doMem && !memDone) ? v.we : 1'b0;
                if (portAddr !== eAddr || portWe !== eWe) portBad = 1;
                if (eWe && portWData !== v.wd) portBad = 1;
            end
            if (memValid) begin
                memCnt++;
                memDone = 1;
                check("memValid cycle", i, expMemAt);
                if (!v.we) lastRData = memF(v.ma);
                check("memRData", memRData, lastRData);
                if (v.we) begin
                    check("store addr", lastWAddr, v.ma);
                    check("store data", lastWData, v.wd);
                end
                memReq = 1'b0;
            end
            if (ifValid) begin
                ifCnt++;
                check("ifValid cycle", i, expIfAt);
                check("ifData", ifData, memF(v.ia));
                ifReq = 1'b0;
            end
            if (i == v.flushAt) begin
                ifFlush = 1'b1;
                ifReq   = 1'b0;
            end else begin
                ifFlush = 1'b0;
            end
            // already latched: later changes must not reach the port
            if (i == 1 && v.doMem) begin
                memAddr  = ~v.ma;
                memWData = ~v.wd;
            end
        end
        check("memValid count", memCnt, v.doMem);
        check("ifValid count", ifCnt, v.doIf && v.flushAt < 0);
        check("port values held", portBad, 1'b0);
        check("portReq idle at end", portReq, 1'b0);
        ifReq = 1'b0; memReq = 1'b0; ifFlush = 1'b0;
    endtask

    vec_t tbl[7];

    initial begin
        int hit, hitErr;
        logic [31:0] hitData;
        bit holdOk;

        // reset state
        #3;
        check("rst portReq", portReq, 1'b0);
        check("rst portWe", portWe, 1'b0);
        check("rst portAddr", portAddr, 32'h0);
        check("rst portWData", portWData, 32'h0);
        check("rst ifValid", ifValid, 1'b0);
        check("rst memValid", memValid, 1'b0);
        check("rst ifData", ifData, 32'h0);
        check("rst memRData", memRData, 32'h0);
        check("rst errTimeout", errTimeout, 1'b0);
        check("rst PCWrite", PCWrite, 1'b0);
        check("rst IF_ID_Write", IF_ID_Write, 1'b0);
        check("rst pipeHold", pipeHold, 1'b1);
        @(negedge clk);
        resetN = 1'b1;

        // directed vectors: doIf doMem we flushAt ia ma wd d
        tbl[0] = '{1'b1, 1'b0, 1'b0, -1, 32'h4,  32'h0,  32'h0,        1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, -1, 32'h8,  32'h40, 32'h0,        1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, -1, 32'h0,  32'h20, 32'hDEADBEEF, 1};
        tbl[3] = '{1'b1, 1'b0, 1'b0,  1, 32'h30, 32'h0,  32'h0,        2};
        tbl[4] = '{1'b1, 1'b0, 1'b0, -1, 32'h34, 32'h0,  32'h0,        0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, -1, 32'h0,  32'h44, 32'h0,        0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, -1, 32'hC,  32'h48, 32'h12345678, 3};
        for (int t = 0; t < 7; t++) runVec(tbl[t]);

        // portAck outside BUSY is ignored
        @(negedge clk);
        forceAck = 1'b1;
        @(negedge clk);
        forceAck = 1'b0;
        hit = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifValid || memValid || portReq) hit++;
        end
        check("stray ack ignored", hit, 0);
        check("memRData after stray ack", memRData, lastRData);

        // BUSY with no ack: abort under the timeout build, wait otherwise
        ackEnable = 1'b0;
        @(negedge clk);
        memReq = 1'b1; memWe = 1'b0; memAddr = 32'h100;
        hit = -1; hitErr = 0; hitData = '0; holdOk = 1;
        for (int i = 1; i <= 30 && hit < 0; i++) begin
            @(negedge clk);
            if (errTimeout) hitErr++;
            if (memValid) begin
                hit = i; hitData = memRData; memReq = 1'b0;
            end else if (!pipeHold) holdOk = 0;
        end
`ifdef ARB_TIMEOUT_EN
        check("timeout valid cycle", hit, TOUT + 1);
        check("timeout errTimeout pulses", hitErr, 1);
        check("timeout errTimeout with memValid", errTimeout, 1'b1);
        check("timeout memRData", hitData, 32'h0);
        lastRData = '0;
        @(negedge clk);
        check("timeout pulse one cycle", errTimeout, 1'b0);
        check("timeout portReq dropped", portReq, 1'b0);
        ackEnable = 1'b1;
`else
        check("no abort without ack", hit, -1);
        check("no errTimeout", hitErr, 0);
        check("pipeHold while waiting", holdOk, 1'b1);
        check("portReq held while waiting", portReq, 1'b1);
        ackEnable = 1'b1;
        hit = -1;
        for (int i = 1; i <= 6 && hit < 0; i++) begin
            @(negedge clk);
            if (memValid) begin
                hit = i; hitData = memRData; memReq = 1'b0;
            end
        end
        check("late ack completes", hit > 0, 1'b1);
        check("late ack memRData", hitData, memF(32'h100));
        lastRData = memF(32'h100);
`endif
        memReq = 1'b0;
        runVec(tbl[0]);

        // reset mid-transaction in BUSY_DM
        ackEnable = 1'b0;
        @(negedge clk);
        memReq = 1'b1; memWe = 1'b0; memAddr = 32'h80;
        repeat (3) @(negedge clk);
        check("busy before reset", portReq, 1'b1);
        resetN = 1'b0;
        #1;
        check("async portReq drop", portReq, 1'b0);
        check("reset portAddr", portAddr, 32'h0);
        check("reset memValid", memValid, 1'b0);
        check("reset memRData", memRData, 32'h0);
        check("reset ifData", ifData, 32'h0);
        check("reset PCWrite", PCWrite, 1'b0);
        check("reset pipeHold", pipeHold, 1'b1);
        memReq = 1'b0;
        ackEnable = 1'b1;
        lastRData = '0;
        @(negedge clk);
        resetN = 1'b1;
        hit = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifValid || memValid || portReq) hit++;
        end
        check("no pulse after reset", hit, 0);

        // randomized accesses
        for (int n = 0; n < 40; n++) begin
            vec_t v;
            int k;
            k = $urandom_range(0, 3);
            v.doIf  = (k == 0) || (k == 3);
            v.doMem = (k >= 1);
            v.we    = (k == 2) || (k == 3 && $urandom_range(0, 1) == 1);
            v.d     = $urandom_range(0, 4);
            v.ia    = $urandom & ~32'h3;
            v.ma    = $urandom & ~32'h3;
            v.wd    = $urandom;
            v.flushAt = -1;
            if (k == 0 && $urandom_range(0, 3) == 0) v.flushAt = $urandom_range(1, 1 + v.d);
            runVec(v);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage MIPS pipeline. It runs a request/grant state machine, drives the memory port handshake, and returns read data to the winning stage. It also generates the stall controls `PCWrite`, `IF_ID_Write` and `pipeHold` that freeze the pipeline while an access is outstanding. It sits between the pipeline stage registers and the memory model.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 15: cycles in BUSY before abort (only when `ARB_TIMEOUT_EN` is defined).

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state changes on the rising edge.
- `resetN` in 1: reset, asynchronous and active-low.
- `ifReq` in 1: fetch request; held high until `ifValid`.
- `ifAddr` in ADDR_W: fetch address (PC).
- `ifFlush` in 1: branch taken; discard any pending or in-flight fetch result.
- `ifValid` out 1: one-cycle pulse; `ifData` is valid.
- `ifData` out DATA_W: fetched instruction.
- `memReq` in 1: data access request (MemRead | MemWrite); held until `memValid`.
- `memWe` in 1: 1 = store, 0 = load.
- `memAddr` in ADDR_W: data address (ALU result).
- `memWData` in DATA_W: store data (ReadData2).
- `memValid` out 1: one-cycle pulse; access complete.
- `memRData` out DATA_W: load data.
- `portReq` out 1: memory port request; held until `portAck`.
- `portWe` out 1: port write enable.
- `portAddr` out ADDR_W: port address.
- `portWData` out DATA_W: port write data.
- `portAck` in 1: one-cycle pulse; `portRData` is valid.
- `portRData` in DATA_W: port read data.
- `PCWrite` out 1: PC load enable.
- `IF_ID_Write` out 1: IF/ID register load enable.
- `pipeHold` out 1: freeze ID/EX, EX/MEM and MEM/WB.
- `errTimeout` out 1: one-cycle pulse when a transaction is aborted.

## Operation
- States: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE:
  - `memReq` wins over `ifReq`, since the data access belongs to the older instruction. Go to BUSY_DM.
  - Else if `ifReq & ~ifFlush`, go to BUSY_IF.
  - Address, write data and `memWe` are latched into the `port*` registers on this edge.
- BUSY_x: `portReq`=1 with the latched values. On `portAck`:
  - capture `portRData` into `ifData` or `memRData`;
  - drop `portReq`;
  - go to RESP.
- RESP: pulse `ifValid` or `memValid` for this cycle only, then return to IDLE.
- A request still high in the cycle after RESP is treated as a new request.
- Simultaneous requests: the data access is served first. Fetch is served on the next IDLE, with no fetch lost.
- `ifFlush` during BUSY_IF: the port transaction still completes (the port cannot be cancelled). A sticky `flushed` flag then suppresses `ifValid` in RESP. The flag clears in IDLE.
- Stores: `memRData` is left unchanged. `memValid` still pulses.
- Stalls (combinational):
  - `PCWrite` = `IF_ID_Write` = ~((`ifReq` & ~`ifValid` & ~`ifFlush`) | (`memReq` & ~`memValid`)).
  - `pipeHold` = `memReq` & ~`memValid`.
  - While `resetN`=0, `PCWrite`=`IF_ID_Write`=0 and `pipeHold`=1.

## Timing
- Reset values: state IDLE; all other registered outputs 0, i.e. `portReq`, `portWe`, `portAddr`, `portWData`, `ifValid`, `memValid`, `ifData`, `memRData`, `errTimeout`.
- Latency: request seen in IDLE at cycle n; `portReq` high at n+1; `portAck` at cycle k ≥ n+1; valid pulse at k+1; IDLE at k+2.
- Minimum spacing is 3 cycles per access.
- Reset asserted mid-transaction: `portReq` drops immediately (asynchronously). The in-flight access is lost and no valid pulse is produced.
- `portAck` outside BUSY is ignored.
- `ifAddr`, `memAddr` and `memWData` may change after latching; the changes are ignored.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches `TIMEOUT` without `portAck`: drop `portReq`, go to RESP, pulse the valid output with data 0, and pulse `errTimeout` in the same cycle.
- `ARB_TIMEOUT_EN` undefined: BUSY waits indefinitely for `portAck`; `errTimeout` is tied to 0 and no counter is built.

## Structure
- Shared package holds:
  - the state enum (IDLE/BUSY_IF/BUSY_DM/RESP);
  - the `ADDR_W`/`DATA_W` defaults;
  - the `TIMEOUT` default.
- One sub-module, `arb_timeout_counter`: clear and enable inputs, terminal-count output, built only under `ARB_TIMEOUT_EN`.
- The FSM, port registers and stall logic stay in `mem_port_arbiter`.

## Test plan
- Fetch only:
  - Stimulus: `ifReq`=1, `ifAddr`=0x4; memory acks 1 cycle after `portReq`.
  - Required response: `portAddr`=0x4, `portWe`=0; `ifValid` pulse 3 cycles after the request; `ifData`=`portRData`; `PCWrite`=0 until the `ifValid` cycle.
- Simultaneous requests:
  - Stimulus: `ifReq` with `ifAddr`=0x8, plus a `memReq` load with `memAddr`=0x40, in the same cycle.
  - Required response: first port access is to 0x40; `memValid` then `ifValid`; `pipeHold`=1 until `memValid`.
- Store:
  - Stimulus: `memWe`=1, `memAddr`=0x20, `memWData`=0xDEADBEEF.
  - Required response: `portWe`=1 with those values; `memValid` pulses; `memRData` unchanged.
- Flush:
  - Stimulus: `ifFlush` asserted during BUSY_IF.
  - Required response: port access completes; no `ifValid`; next fetch starts from IDLE.
- Reset mid-transaction:
  - Stimulus: drop `resetN` during BUSY_DM.
  - Required response: `portReq`=0 asynchronously; all outputs at reset values; no valid pulse.
- Timeout (with `ARB_TIMEOUT_EN`, `TIMEOUT`=15):
  - Stimulus: `portAck` never arrives.
  - Required response: `errTimeout` and `memValid` pulse together; `memRData`=0; back to IDLE.
